f_backup_stack: RTL and testbench

LIFO backup store for the 256-bit F-register file. A `backup` pulse pushes the current register image onto an on-chip stack. A `restore` pulse pops the most recent image and presents it on `dataOut` for the register file to reload. It sits beside the F-register file, which drives `dataIn` and consumes `dataOut`/`restoreOut`.

---
 rtl/fbs_pkg.sv | 8 +
 rtl/f_backup_stack_fcache.sv | 34 +++
 rtl/f_backup_stack.sv | 45 ++++
 tb/tb_f_backup_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fbs_pkg.sv
// fbs_pkg: shared sizes and types for the F-register backup stack
package fbs_pkg;
   localparam int DATA_W = 256;
   localparam int DEPTH  = 16;
   localparam int PTR_W  = 16;
   typedef logic [DATA_W-1:0] fimage_t;
   typedef logic [PTR_W-1:0]  fptr_t;
endpackage

// File: rtl/f_backup_stack_fcache.sv
// fcache: image store with synchronous write and asynchronous read, plus the 16-bit datapath primitives
module fcache #(
   parameter int DATA_W = fbs_pkg::DATA_W,
   parameter int DEPTH  = fbs_pkg::DEPTH,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              write,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wData,
   input  logic [AW-1:0]     rAddr,
   output logic [DATA_W-1:0] rData
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   always_ff @(posedge clk) if (write) r_mem[addr] <= wData;
   assign rData = r_mem[rAddr];
endmodule

module adder_16_bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] R
);
   assign R = A + B;
endmodule

module mux_1_bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        S,
   output logic [15:0] R
);
   assign R = S ? B : A;
endmodule

// File: rtl/f_backup_stack.sv
// f_backup_stack: LIFO of F-register images; backup pushes, restore pops (backup wins)
module f_backup_stack #(
   parameter int DATA_W = fbs_pkg::DATA_W,
   parameter int DEPTH  = fbs_pkg::DEPTH,
   parameter int PTR_W  = fbs_pkg::PTR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              backup,
   input  logic              restore,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] dataOut,
   output logic              restoreOut,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
   localparam logic [PTR_W-1:0] NEG_ONE = '1;
   logic [PTR_W-1:0]  r_fcc, w_step, w_sum, w_addr, w_rd;
   logic [DATA_W-1:0] w_rdata;
   logic              w_push, w_pop, w_we;
   mux_1_bit    u_step (.A(NEG_ONE), .B(ONE), .S(backup), .R(w_step));
   adder_16_bit u_add  (.A(r_fcc), .B(w_step), .R(w_sum));
   mux_1_bit    u_addr (.A(w_sum), .B(r_fcc), .S(backup), .R(w_addr));
   // top-of-stack read must stay at FCC-1 even while a push is being addressed
   adder_16_bit u_rd   (.A(r_fcc), .B(NEG_ONE), .R(w_rd));
   assign full       = r_fcc == DEPTH_P;
   assign empty      = r_fcc == '0;
   assign w_push     = backup & ~full;
   assign w_pop      = restore & ~backup & ~empty;
   assign restoreOut = w_pop;
   assign w_we       = w_push & rst_n & (w_addr < DEPTH_P);
   // FCC-1 wraps to all-ones when empty, which lands out of range and yields zero
   assign dataOut    = (w_rd < DEPTH_P) ? w_rdata : '0;
   fcache #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cache (
      .clk(clk), .write(w_we), .addr(w_addr[AW-1:0]), .wData(dataIn),
      .rAddr(w_rd[AW-1:0]), .rData(w_rdata)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fcc <= '0;
      else if (w_push | w_pop) r_fcc <= w_sum;
   end
endmodule

// File: tb/tb_f_backup_stack.sv
// tb_f_backup_stack: randomized and directed checks against a queue-based LIFO model
module tb_f_backup_stack;
   localparam int W = 256;
   localparam int D = 16;
   logic clk = 0, rst_n = 0, backup = 0, restore = 0;
   logic [W-1:0] dataIn = '0, dataOut;
   logic restoreOut, full, empty;
   int total = 0, bad = 0;
   logic [W-1:0] stk[$];

   f_backup_stack dut (.clk(clk), .rst_n(rst_n), .backup(backup), .restore(restore),
      .dataIn(dataIn), .dataOut(dataOut), .restoreOut(restoreOut), .full(full), .empty(empty));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] top_img();
      return stk.size() > 0 ? stk[$] : '0;
   endfunction

   function automatic logic [W-1:0] rnd_img();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // drive one request from a negedge, let the edge happen, update the model, return at next negedge
   task automatic cycle(input logic b, input logic r, input logic [W-1:0] d);
      backup = b; restore = r; dataIn = d;
      @(posedge clk);
      if (b) begin
         if (stk.size() < D) stk.push_back(d);
      end else if (r && stk.size() > 0) void'(stk.pop_back());
      @(negedge clk);
      backup = 0; restore = 0;
   endtask

   task automatic test_reset();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
      total++; if (dataOut !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", dataOut); end
      total++; if (restoreOut !== 1'b0) begin bad++; $display("FAIL reset_restoreOut got=%b want=0", restoreOut); end
   endtask

   task automatic test_push_pop();
      logic [W-1:0] a = {(W/4){4'hA}}, f = {(W/4){4'h5}};
      cycle(1, 0, a);
      cycle(1, 0, f);
      total++; if (dataOut !== f) begin bad++; $display("FAIL pp_top got=%h want=%h", dataOut, f); end
      restore = 1; #1;
      total++; if (dataOut !== f) begin bad++; $display("FAIL pp_during got=%h want=%h", dataOut, f); end
      total++; if (restoreOut !== 1'b1) begin bad++; $display("FAIL pp_restoreOut got=%b want=1", restoreOut); end
      cycle(0, 1, '0);
      total++; if (dataOut !== a) begin bad++; $display("FAIL pp_after got=%h want=%h", dataOut, a); end
      cycle(0, 1, '0);
   endtask

   task automatic test_full();
      for (int i = 0; i < D; i++) cycle(1, 0, W'(i));
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full); end
      cycle(1, 0, W'(99));
      total++; if (dataOut !== W'(D - 1)) begin bad++; $display("FAIL full_ignored got=%h want=%h", dataOut, W'(D - 1)); end
      for (int i = D - 1; i >= 0; i--) begin
         restore = 1; #1;
         total++; if (dataOut !== W'(i) || restoreOut !== 1'b1) begin
            bad++; $display("FAIL full_pop%0d got=%h/%b want=%h/1", i, dataOut, restoreOut, W'(i)); end
         cycle(0, 1, '0);
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b want=1", empty); end
   endtask

   task automatic test_empty_pop();
      restore = 1; #1;
      total++; if (restoreOut !== 1'b0) begin bad++; $display("FAIL ep_restoreOut got=%b want=0", restoreOut); end
      cycle(0, 1, '0);
      total++; if (empty !== 1'b1 || dataOut !== '0) begin
         bad++; $display("FAIL ep_state got=%b/%h want=1/0", empty, dataOut); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] v;
      for (int i = 0; i < 3; i++) cycle(1, 0, rnd_img());
      v = rnd_img();
      backup = 1; restore = 1; dataIn = v; #1;
      total++; if (restoreOut !== 1'b0) begin bad++; $display("FAIL both_restoreOut got=%b want=0", restoreOut); end
      cycle(1, 1, v);
      total++; if (dataOut !== v) begin bad++; $display("FAIL both_top got=%h want=%h", dataOut, v); end
      for (int i = 0; i < 4; i++) begin
         total++; if (dataOut !== top_img()) begin bad++; $display("FAIL both_drain%0d got=%h want=%h", i, dataOut, top_img()); end
         cycle(0, 1, '0);
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL both_empty got=%b want=1", empty); end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] v;
      for (int i = 0; i < 5; i++) cycle(1, 0, rnd_img());
      backup = 1; dataIn = rnd_img();
      #2 rst_n = 0; #1;
      total++; if (empty !== 1'b1 || dataOut !== '0) begin
         bad++; $display("FAIL arst_now got=%b/%h want=1/0", empty, dataOut); end
      @(posedge clk); @(negedge clk);
      stk.delete();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL arst_hold got=%b want=1", empty); end
      backup = 0; rst_n = 1;
      v = rnd_img();
      cycle(1, 0, v);
      total++; if (dataOut !== v) begin bad++; $display("FAIL arst_push got=%h want=%h", dataOut, v); end
      cycle(0, 1, '0);
      total++; if (empty !== 1'b1 || dataOut !== '0) begin
         bad++; $display("FAIL arst_pop got=%b/%h want=1/0", empty, dataOut); end
   endtask

   task automatic test_random();
      logic b, r;
      logic [W-1:0] d;
      for (int i = 0; i < 400; i++) begin
         b = ($urandom_range(0, 99) < 45); r = ($urandom_range(0, 99) < 50); d = rnd_img();
         backup = b; restore = r; dataIn = d; #1;
         total++; if (restoreOut !== (r && !b && stk.size() > 0)) begin
            bad++; $display("FAIL rnd_restoreOut%0d got=%b", i, restoreOut); end
         total++; if (dataOut !== top_img()) begin bad++; $display("FAIL rnd_data%0d got=%h want=%h", i, dataOut, top_img()); end
         cycle(b, r, d);
         total++; if (full !== (stk.size() == D) || empty !== (stk.size() == 0)) begin
            bad++; $display("FAIL rnd_flags%0d got=%b%b want=%b%b", i, full, empty, stk.size() == D, stk.size() == 0); end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1;
      @(negedge clk);
      test_reset();
      test_push_pop();
      test_full();
      test_empty_pop();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
